return_addr_stack: RTL and testbench

//  Parametrised return-address stack (RAS) for the pipelined datapath; successor to the fixed 12-bit call/return stack.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/ras_storage.sv | 24 ++
 rtl/return_addr_stack.sv | 132 +++++++++++++
 tb/tb_return_addr_stack.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath types: PC width, PC type and RAS overflow policy
package cpu_pkg;

  localparam int ADDR_W = 12;

  typedef logic [ADDR_W-1:0] pc_t;

  typedef enum logic {
    OVF_WRAP   = 1'b0,
    OVF_REJECT = 1'b1
  } ovf_mode_e;

endpackage

// File: rtl/ras_storage.sv
// rtl/ras_storage.sv - DEPTH x ADDR_W register file, one write port, one combinational read port
module ras_storage #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     wrEn,
  input  logic [$clog2(DEPTH)-1:0] wrAddr,
  input  logic [ADDR_W-1:0]        wrData,
  input  logic [$clog2(DEPTH)-1:0] rdAddr,
  output logic [ADDR_W-1:0]        rdData
);

  logic [ADDR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - return-address stack with wrap/reject overflow policy
// Optional flush checkpointing of {tos, count} when RAS_CHECKPOINT_EN is defined.
module return_addr_stack #(
  parameter int ADDR_W        = cpu_pkg::ADDR_W,
  parameter int DEPTH         = 8,
  parameter int OVERFLOW_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_data,
`ifdef RAS_CHECKPOINT_EN
  input  logic                       ckpt_save,
  input  logic                       ckpt_restore,
`endif
  output logic [ADDR_W-1:0]          top_data,
  output logic                       top_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  import cpu_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] TOS_RESET = PTR_W'(DEPTH - 1);
  localparam bit REJECT = (OVERFLOW_MODE == int'(OVF_REJECT));

  logic [PTR_W-1:0]  tos, nextTos, wrAddr;
  logic [CNT_W-1:0]  cnt, nextCnt;
  logic              ovfQ, unfQ, ovfNext, unfNext;
  logic              wrEn, isEmpty, isFull;
  logic [ADDR_W-1:0] rdData;

`ifdef RAS_CHECKPOINT_EN
  logic [PTR_W-1:0] shadowTos;
  logic [CNT_W-1:0] shadowCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadowTos <= TOS_RESET;
      shadowCnt <= '0;
    end else if (ckpt_save && !ckpt_restore) begin
      shadowTos <= tos;
      shadowCnt <= cnt;
    end
  end
`endif

  assign isEmpty = (cnt == '0);
  assign isFull  = (cnt == CNT_FULL);

  always_comb begin
    nextTos = tos;
    nextCnt = cnt;
    wrEn    = 1'b0;
    wrAddr  = tos + 1'b1;
    ovfNext = 1'b0;
    unfNext = 1'b0;
`ifdef RAS_CHECKPOINT_EN
    if (ckpt_restore) begin
      nextTos = shadowTos;
      nextCnt = shadowCnt;
    end else
`endif
    if (push && pop && !isEmpty) begin
      // CALL and RET in the same cycle: the new address replaces the top
      wrEn   = 1'b1;
      wrAddr = tos;
    end else if (push) begin
      unfNext = pop;
      if (isFull) begin
        ovfNext = 1'b1;
        if (!REJECT) begin
          wrEn    = 1'b1;
          nextTos = tos + 1'b1;
        end
      end else begin
        wrEn    = 1'b1;
        nextTos = tos + 1'b1;
        nextCnt = cnt + 1'b1;
      end
    end else if (pop) begin
      if (isEmpty) begin
        unfNext = 1'b1;
      end else begin
        nextTos = tos - 1'b1;
        nextCnt = cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tos  <= TOS_RESET;
      cnt  <= '0;
      ovfQ <= 1'b0;
      unfQ <= 1'b0;
    end else begin
      tos  <= nextTos;
      cnt  <= nextCnt;
      ovfQ <= ovfNext;
      unfQ <= unfNext;
    end
  end

  ras_storage #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) storage (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (push_data),
    .rdAddr (tos),
    .rdData (rdData)
  );

  assign top_data  = isEmpty ? '0 : rdData;
  assign top_valid = !isEmpty;
  assign empty     = isEmpty;
  assign full      = isFull;
  assign count     = cnt;
  assign overflow  = ovfQ;
  assign underflow = unfQ;

endmodule

// File: tb/tb_return_addr_stack.sv
// tb/tb_return_addr_stack.sv - scoreboard bench: wrap-mode and reject-mode stacks under shared stimulus
module tb_return_addr_stack;

  localparam int DEPTH = 4;
  localparam int AW    = 12;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [AW-1:0] top;
    logic          valid;
    logic          empty;
    logic          full;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          unf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, push = 1'b0, pop = 1'b0, ckSave = 1'b0, ckRestore = 1'b0;
  logic [AW-1:0] pushData = '0;

  logic [AW-1:0] topD [2];
  logic [CW-1:0] cnt  [2];
  logic          topV [2];
  logic          emp  [2];
  logic          ful  [2];
  logic          ovf  [2];
  logic          unf  [2];

  return_addr_stack #(.ADDR_W(AW), .DEPTH(DEPTH), .OVERFLOW_MODE(0)) dutWrap (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(pushData),
`ifdef RAS_CHECKPOINT_EN
    .ckpt_save(ckSave), .ckpt_restore(ckRestore),
`endif
    .top_data(topD[0]), .top_valid(topV[0]), .empty(emp[0]), .full(ful[0]),
    .count(cnt[0]), .overflow(ovf[0]), .underflow(unf[0])
  );

  return_addr_stack #(.ADDR_W(AW), .DEPTH(DEPTH), .OVERFLOW_MODE(1)) dutReject (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(pushData),
`ifdef RAS_CHECKPOINT_EN
    .ckpt_save(ckSave), .ckpt_restore(ckRestore),
`endif
    .top_data(topD[1]), .top_valid(topV[1]), .empty(emp[1]), .full(ful[1]),
    .count(cnt[1]), .overflow(ovf[1]), .underflow(unf[1])
  );

  // Reference model: circular slot array, top index and occupancy; index 0 wraps, index 1 rejects.
  logic [AW-1:0] mMem [2][DEPTH];
  int mTop [2], mCnt [2], mShTop [2], mShCnt [2];
  exp_t expQ0 [$];
  exp_t expQ1 [$];
  int checks = 0, passed = 0;

  function automatic exp_t step(int i, bit r, bit pu, bit po, logic [AW-1:0] d, bit sv, bit rs);
    exp_t e;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (r) begin
      mTop[i] = DEPTH - 1; mCnt[i] = 0; mShTop[i] = DEPTH - 1; mShCnt[i] = 0;
    end else if (rs) begin
      mTop[i] = mShTop[i]; mCnt[i] = mShCnt[i];
    end else begin
      if (sv) begin
        mShTop[i] = mTop[i]; mShCnt[i] = mCnt[i];
      end
      if (pu && po && mCnt[i] > 0) begin
        mMem[i][mTop[i]] = d;
      end else if (pu && mCnt[i] == DEPTH) begin
        e.ovf = 1'b1;
        if (i == 0) begin
          mTop[i] = (mTop[i] + 1) % DEPTH;
          mMem[i][mTop[i]] = d;
        end
      end else if (pu) begin
        e.unf = po;
        mTop[i] = (mTop[i] + 1) % DEPTH;
        mMem[i][mTop[i]] = d;
        mCnt[i] = mCnt[i] + 1;
      end else if (po) begin
        if (mCnt[i] == 0) e.unf = 1'b1;
        else begin
          mTop[i] = (mTop[i] + DEPTH - 1) % DEPTH;
          mCnt[i] = mCnt[i] - 1;
        end
      end
    end
    e.cnt   = CW'(mCnt[i]);
    e.empty = (mCnt[i] == 0);
    e.full  = (mCnt[i] == DEPTH);
    e.valid = (mCnt[i] != 0);
    e.top   = (mCnt[i] == 0) ? '0 : mMem[i][mTop[i]];
    return e;
  endfunction

  task automatic cyc(bit r, bit pu, bit po, logic [AW-1:0] d, bit sv = 1'b0, bit rs = 1'b0);
    @(negedge clk);
    rst = r; push = pu; pop = po; pushData = d; ckSave = sv; ckRestore = rs;
    expQ0.push_back(step(0, r, pu, po, d, sv, rs));
    expQ1.push_back(step(1, r, pu, po, d, sv, rs));
  endtask

  task automatic cmp(string name, int inst, logic [AW-1:0] act, logic [AW-1:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s[%0d] at %0t: got 0x%h, expected 0x%h", name, inst, $time, act, want);
  endtask

  task automatic checkAll(int i, exp_t e);
    cmp("top_data",  i, topD[i], e.top);
    cmp("top_valid", i, AW'(topV[i]), AW'(e.valid));
    cmp("empty",     i, AW'(emp[i]),  AW'(e.empty));
    cmp("full",      i, AW'(ful[i]),  AW'(e.full));
    cmp("count",     i, AW'(cnt[i]),  AW'(e.cnt));
    cmp("overflow",  i, AW'(ovf[i]),  AW'(e.ovf));
    cmp("underflow", i, AW'(unf[i]),  AW'(e.unf));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (expQ0.size() > 0) checkAll(0, expQ0.pop_front());
      if (expQ1.size() > 0) checkAll(1, expQ1.pop_front());
    end
  end

  initial begin
    int guard;
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    // basic push/pop order
    cyc(0, 1, 0, 12'h010); cyc(0, 1, 0, 12'h020); cyc(0, 1, 0, 12'h030);
    cyc(0, 0, 1, '0); cyc(0, 0, 1, '0); cyc(0, 0, 1, '0);
    // pop on empty, then the underflow pulse must drop
    cyc(0, 0, 1, '0); cyc(0, 0, 0, '0); cyc(0, 0, 0, '0);
    // overflow: wrap keeps 5..2, reject keeps 4..1
    for (int k = 1; k <= 5; k++) cyc(0, 1, 0, AW'(k));
    cyc(0, 0, 0, '0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, '0);
    // replace top
    cyc(0, 1, 0, 12'h100); cyc(0, 1, 0, 12'h200); cyc(0, 1, 1, 12'h2AA);
    cyc(0, 0, 1, '0); cyc(0, 0, 1, '0);
    // push and pop together on empty
    cyc(0, 1, 1, 12'h3C3); cyc(0, 0, 1, '0);
    // push+pop when full replaces the top without overflow
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, AW'(12'h40 + k));
    cyc(0, 1, 1, 12'h5A5); cyc(0, 0, 1, '0);
`ifdef RAS_CHECKPOINT_EN
    cyc(1, 0, 0, '0);
    cyc(0, 0, 0, '0, 1'b0, 1'b1);
    cyc(0, 1, 0, 12'h00A); cyc(0, 0, 0, '0, 1'b1, 1'b0);
    cyc(0, 1, 0, 12'h00B); cyc(0, 1, 0, 12'h00C);
    cyc(0, 0, 0, '0, 1'b0, 1'b1);
    cyc(0, 1, 0, 12'h00D, 1'b0, 1'b1);
    cyc(0, 1, 0, 12'h00E); cyc(0, 0, 0, '0, 1'b1, 1'b1);
    cyc(0, 0, 1, '0); cyc(0, 0, 0, '0, 1'b0, 1'b1);
`endif
    for (int n = 0; n < 600; n++) begin
      bit r, pu, po, sv, rs;
      r  = ($urandom_range(0, 99) < 2);
      pu = ($urandom_range(0, 99) < ((n % 200) < 100 ? 65 : 35));
      po = ($urandom_range(0, 99) < ((n % 200) < 100 ? 35 : 65));
      sv = 1'b0;
      rs = 1'b0;
`ifdef RAS_CHECKPOINT_EN
      sv = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 11) == 0);
`endif
      cyc(r, pu, po, AW'($urandom), sv, rs);
    end
    cyc(0, 0, 0, '0);
    guard = 0;
    while ((expQ0.size() > 0 || expQ1.size() > 0) && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    cmp("drain", 0, AW'(expQ0.size()), '0);
    cmp("drain", 1, AW'(expQ1.size()), '0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
